// File: rtl/extmem_pkg.sv
// Shared types and widths for the external-memory arbiter slice.
// Default word/address widths apply when the platform does not define
// ADDR_EXT_RAM / DATA_EXT_RAM.
`ifndef ADDR_EXT_RAM
`define ADDR_EXT_RAM 12
`endif
`ifndef DATA_EXT_RAM
`define DATA_EXT_RAM 16
`endif

package extmem_pkg;

  localparam int EXT_ADDR_W = `ADDR_EXT_RAM;
  localparam int EXT_DATA_W = `DATA_EXT_RAM;
  localparam int LEN_W      = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // One burst command as presented by a requester.
  typedef struct packed {
    logic                  we;
    logic [EXT_ADDR_W-1:0] addr;
    logic [LEN_W-1:0]      len;
  } burst_cmd_t;

endpackage

// File: rtl/extmem_arbiter_rr_arbiter.sv
// Combinational one-hot round-robin picker. Searches upward from
// rr_ptr+1 with wrap and grants the first active request.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  // Scan the requests in rotated priority order, keep the first hit.
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/extmem_arbiter.sv
// Round-robin arbiter and burst sequencer for the single-port external
// memory. One requester owns the port per burst; one beat per cycle.
// Optional statistics counters are built when EXTMEM_ARB_STATS_EN is defined.
module extmem_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = extmem_pkg::EXT_ADDR_W,
  parameter int DATA_W  = extmem_pkg::EXT_DATA_W,
  parameter int LEN_W   = extmem_pkg::LEN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    wr_beat,
  output logic [NUM_REQ-1:0]    rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy,
`ifdef EXTMEM_ARB_STATS_EN
  output logic [31:0]           stat_busy_cycles,
  output logic [NUM_REQ*16-1:0] stat_bursts,
`endif
  output logic                  mem_re,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic [DATA_W-1:0]     mem_rd_data,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_wr_addr,
  output logic [DATA_W-1:0]     mem_wr_data
);

  import extmem_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [PTR_W-1:0]    r_owner;
  logic [PTR_W-1:0]    r_owner_d;
  logic                r_we;
  logic                r_re_d;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_count;

  logic [NUM_REQ-1:0]  w_pick;
  logic [PTR_W-1:0]    w_pick_idx;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [LEN_W-1:0]    w_sel_len;
  logic [NUM_REQ-1:0]  w_owner_oh;
  logic [NUM_REQ-1:0]  w_owner_d_oh;
  logic                w_take;
  logic                w_last_beat;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .grant  (w_pick)
  );

  // Encode the picked requester and select its command fields.
  always_comb begin
    w_pick_idx = '0;
    w_sel_we   = 1'b0;
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) begin
        w_pick_idx = PTR_W'(i);
        w_sel_we   = req_we[i];
        w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_len  = req_len[i*LEN_W +: LEN_W];
      end else begin
        w_pick_idx = w_pick_idx;
      end
    end
  end

  // Decode current and delayed owner, and mux the owner's write data.
  always_comb begin
    w_owner_oh   = '0;
    w_owner_d_oh = '0;
    mem_wr_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == PTR_W'(i)) begin
        w_owner_oh[i] = 1'b1;
        mem_wr_data   = req_wdata[i*DATA_W +: DATA_W];
      end else begin
        w_owner_oh[i] = 1'b0;
      end
      if (r_owner_d == PTR_W'(i)) begin
        w_owner_d_oh[i] = 1'b1;
      end else begin
        w_owner_d_oh[i] = 1'b0;
      end
    end
  end

  // A new command is only accepted from IDLE and never while resetting.
  assign w_take      = (r_state == IDLE) && !rst && (|w_pick);
  assign w_last_beat = (r_state == BURST) && (r_count == '0);

  // Next-state logic: IDLE arbitrates, BURST runs until the last beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_take) begin
          w_state_nxt = BURST;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BURST: begin
        if (w_last_beat) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = BURST;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy        = (r_state == BURST);
  assign mem_re      = busy && !r_we;
  assign mem_we      = busy && r_we;
  assign mem_rd_addr = r_addr;
  assign mem_wr_addr = r_addr;
  assign grant       = w_take ? w_pick : '0;
  assign wr_beat     = mem_we ? w_owner_oh : '0;
  assign done        = w_last_beat ? w_owner_oh : '0;
  assign rd_valid    = r_re_d ? w_owner_d_oh : '0;
  assign rd_data     = mem_rd_data;

  // State, captured command, beat counters and the read-return tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rr_ptr  <= PTR_W'(NUM_REQ - 1);
      r_owner   <= '0;
      r_owner_d <= '0;
      r_we      <= 1'b0;
      r_re_d    <= 1'b0;
      r_addr    <= '0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_re_d    <= mem_re;
      r_owner_d <= r_owner;
      if (w_take) begin
        r_owner  <= w_pick_idx;
        r_rr_ptr <= w_pick_idx;
        r_we     <= w_sel_we;
        r_addr   <= w_sel_addr;
        r_count  <= w_sel_len;
      end else if (r_state == BURST) begin
        r_addr  <= r_addr + ADDR_W'(1);
        r_count <= r_count - LEN_W'(1);
      end
    end
  end

`ifdef EXTMEM_ARB_STATS_EN
  logic [31:0]           r_stat_busy;
  logic [NUM_REQ*16-1:0] r_stat_bursts;

  // Saturating busy-cycle and per-requester grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_busy   <= '0;
      r_stat_bursts <= '0;
    end else begin
      if (busy && (r_stat_busy != 32'hFFFF_FFFF)) begin
        r_stat_busy <= r_stat_busy + 32'd1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (r_stat_bursts[i*16 +: 16] != 16'hFFFF)) begin
          r_stat_bursts[i*16 +: 16] <= r_stat_bursts[i*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign stat_busy_cycles = r_stat_busy;
  assign stat_bursts      = r_stat_bursts;
`endif

endmodule

// File: tb/tb_extmem_arbiter.sv
// Self-checking bench for extmem_arbiter: a transaction-level reference
// model checks every cycle, directed bursts come from a vector table,
// and hand sequences cover contention, long bursts and mid-burst reset.
module tb_extmem_arbiter;
  import extmem_pkg::*;

  localparam int NR    = 3;
  localparam int AW    = EXT_ADDR_W;
  localparam int DW    = EXT_DATA_W;
  localparam int LW    = LEN_W;
  localparam int AMASK = (1 << AW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     req_we = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*LW-1:0]  req_len = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     grant, wr_beat, rd_valid, done;
  logic [DW-1:0]     rd_data;
  logic              busy, mem_re, mem_we;
  logic [AW-1:0]     mem_rd_addr, mem_wr_addr;
  logic [DW-1:0]     mem_rd_data = '0;
  logic [DW-1:0]     mem_wr_data;
`ifdef EXTMEM_ARB_STATS_EN
  logic [31:0]       stat_busy_cycles;
  logic [NR*16-1:0]  stat_bursts;
`endif

  extmem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .grant(grant), .wr_beat(wr_beat),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .busy(busy),
`ifdef EXTMEM_ARB_STATS_EN
    .stat_busy_cycles(stat_busy_cycles), .stat_bursts(stat_bursts),
`endif
    .mem_re(mem_re), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_we(mem_we), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  // External memory: registered read, one-cycle latency.
  logic [DW-1:0] mem     [0:AMASK];
  logic [DW-1:0] ref_mem [0:AMASK];
  always @(posedge clk) begin
    if (mem_we) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_re) mem_rd_data <= mem[mem_rd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int a);
    return DW'(a * 37 + 20480);
  endfunction

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Requester side state, driven onto the ports every negedge.
  logic [NR-1:0] pend = '0;
  logic [NR-1:0] hold = '0;
  logic          cwe  [NR];
  int            caddr[NR];
  int            clen [NR];
  logic [DW-1:0] cwd  [NR];
  bit            rand_en = 1'b0;

  // Reference model state (beats remaining, owner, next address, pointer).
  int            m_left = 0;
  int            m_owner = 0;
  int            m_ptr = NR - 1;
  int            m_addr = 0;
  bit            m_we = 1'b0;
  bit            m_rdv = 1'b0;
  int            m_rdv_owner = 0;
  logic [DW-1:0] m_rdv_data = '0;
  logic [NR-1:0] m_last_grant = '0;
  logic [NR-1:0] m_last_wrbeat = '0;
  bit            chk_en = 1'b0;

  task automatic issue(input int who, input bit we, input int addr, input int len, input logic [DW-1:0] wd);
    cwe[who]   = we;
    caddr[who] = addr;
    clen[who]  = len;
    cwd[who]   = wd;
    pend[who]  = 1'b1;
  endtask

  // Requester behaviour: drop req after grant, advance data after wr_beat.
  initial begin
    for (int i = 0; i < NR; i++) begin
      cwe[i] = 1'b0; caddr[i] = 0; clen[i] = 0; cwd[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (m_last_grant[i] && !hold[i]) pend[i] = 1'b0;
        if (m_last_wrbeat[i]) cwd[i] = cwd[i] + DW'(1);
        if (rand_en && !pend[i] && !(m_left > 0 && m_owner == i) && $urandom_range(0, 3) == 0) begin
          pend[i]  = 1'b1;
          cwe[i]   = 1'($urandom_range(0, 1));
          caddr[i] = $urandom_range(0, AMASK);
          clen[i]  = $urandom_range(0, 6);
          cwd[i]   = DW'($urandom);
        end
      end
      for (int i = 0; i < NR; i++) begin
        req[i] = pend[i];
        req_we[i] = cwe[i];
        req_addr[i*AW +: AW] = AW'(caddr[i]);
        req_len[i*LW +: LW] = LW'(clen[i]);
        req_wdata[i*DW +: DW] = cwd[i];
      end
    end
  end

  // Reference model: predicts this cycle's outputs, then advances.
  initial forever begin
    logic [NR-1:0] eg, edn, ewb, erv;
    bit            eb, ere, ewe, nrv;
    int            ga, nro;
    logic [DW-1:0] wd, nrd;
    @(negedge clk);
    #2;
    eg = '0;
    ga = -1;
    if (m_left == 0 && !rst) begin
      for (int k = 1; k <= NR; k++) begin
        int i;
        i = (m_ptr + k) % NR;
        if (ga < 0 && req[i]) ga = i;
      end
    end
    if (ga >= 0) eg = oh(ga);
    eb  = (m_left > 0);
    ere = eb && !m_we;
    ewe = eb && m_we;
    edn = (eb && m_left == 1) ? oh(m_owner) : '0;
    ewb = ewe ? oh(m_owner) : '0;
    erv = m_rdv ? oh(m_rdv_owner) : '0;
    wd  = req_wdata[m_owner*DW +: DW];
    if (chk_en) begin
      check("grant", grant, eg);
      check("wr_beat", wr_beat, ewb);
      check("rd_valid", rd_valid, erv);
      check("done", done, edn);
      check("busy", busy, eb);
      check("mem_re", mem_re, ere);
      check("mem_we", mem_we, ewe);
      check("re_we_excl", mem_re & mem_we, 0);
      if (ere) check("rd_addr", mem_rd_addr, m_addr);
      if (ewe) begin
        check("wr_addr", mem_wr_addr, m_addr);
        check("wr_data", mem_wr_data, wd);
      end
      if (m_rdv) check("rd_data", rd_data, m_rdv_data);
    end
    nrv = ere;
    nro = m_owner;
    nrd = ref_mem[m_addr];
    if (ewe) ref_mem[m_addr] = wd;
    m_last_grant  = eg;
    m_last_wrbeat = ewb;
    if (rst) begin
      m_left = 0; m_ptr = NR - 1; m_addr = 0; m_owner = 0; m_we = 1'b0;
      m_rdv = 1'b0; m_last_grant = '0; m_last_wrbeat = '0;
    end else begin
      if (eb) begin
        m_addr = (m_addr + 1) & AMASK;
        m_left--;
      end else if (ga >= 0) begin
        m_owner = ga;
        m_ptr   = ga;
        m_we    = req_we[ga];
        m_addr  = int'(req_addr[ga*AW +: AW]);
        m_left  = int'(req_len[ga*LW +: LW]) + 1;
      end
      m_rdv = nrv; m_rdv_owner = nro; m_rdv_data = nrd;
    end
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < limit; t++) begin
      tick();
      if (busy === 1'b0 && pend == '0 && m_left == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", ok, 1);
    tick();
  endtask

  typedef struct {
    int who; bit we; int addr; int len; logic [DW-1:0] wd;
    int exp_beats; int exp_last; logic [DW-1:0] exp_data;
  } vec_t;

  initial begin : main
    vec_t tbl[7];
    int gseq[$];
    int gcyc[$];
    int beats, last, tdone, tg, tgr;
    bit got, dn;
    logic [DW-1:0] data;

    #1000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin : stim
    vec_t tbl[7];
    int gseq[$];
    int gcyc[$];
    int beats, last, tdone, tg, tgr;
    bit got, dn;
    logic [DW-1:0] data;

    for (int a = 0; a <= AMASK; a++) begin
      mem[a] = pat(a);
      ref_mem[a] = pat(a);
    end
    mem[16'h10] = 16'hAAA1; mem[16'h11] = 16'hBBB2; mem[16'h12] = 16'hCCC3; mem[16'h13] = 16'hDDD4;
    ref_mem[16'h10] = 16'hAAA1; ref_mem[16'h11] = 16'hBBB2; ref_mem[16'h12] = 16'hCCC3; ref_mem[16'h13] = 16'hDDD4;

    tbl[0] = '{0, 1'b0, 'h010,   3, 16'h0000,   4, 'h013, 16'hAAA1};
    tbl[1] = '{1, 1'b1, 'h200,   0, 16'hCAFE,   1, 'h200, 16'hCAFE};
    tbl[2] = '{2, 1'b0, 'h200,   0, 16'h0000,   1, 'h200, 16'hCAFE};
    tbl[3] = '{0, 1'b0, AMASK-1, 3, 16'h0000,   4, 'h001, pat(AMASK-1)};
    tbl[4] = '{1, 1'b1, 'h0F0,   7, 16'h1230,   8, 'h0F7, 16'h1230};
    tbl[5] = '{2, 1'b0, 'h0F3,   2, 16'h0000,   3, 'h0F5, 16'h1233};
    tbl[6] = '{0, 1'b0, 'h100, 255, 16'h0000, 256, 'h1FF, pat('h100)};

    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    #2;
    check("rst_busy", busy, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);

    // Contention: all requesters held high, two-beat reads.
    hold = '1;
    issue(0, 1'b0, 'h020, 1, '0);
    issue(1, 1'b0, 'h040, 1, '0);
    issue(2, 1'b0, 'h060, 1, '0);
    for (int t = 0; t < 40 && gseq.size() < 6; t++) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (grant[i] === 1'b1) begin
          gseq.push_back(i);
          gcyc.push_back(cyc);
        end
      end
    end
    check("cont_count", gseq.size(), 6);
    for (int k = 0; k < gseq.size(); k++) begin
      check("cont_order", gseq[k], k % NR);
      if (k > 0) check("cont_gap", gcyc[k] - gcyc[k-1], 3);
    end
    hold = '0;
    wait_idle(60);

    // Table of single bursts: beat count, last address, first data word.
    for (int v = 0; v < 7; v++) begin
      issue(tbl[v].who, tbl[v].we, tbl[v].addr, tbl[v].len, tbl[v].wd);
      beats = 0; last = -1; got = 1'b0; dn = 1'b0; data = '0;
      for (int t = 0; t < 400; t++) begin
        tick();
        if (mem_re === 1'b1 || mem_we === 1'b1) begin
          beats++;
          last = (mem_re === 1'b1) ? int'(mem_rd_addr) : int'(mem_wr_addr);
          if (mem_we === 1'b1 && !got) begin
            data = mem_wr_data;
            got = 1'b1;
          end
        end
        if (rd_valid[tbl[v].who] === 1'b1 && !got) begin
          data = rd_data;
          got = 1'b1;
        end
        if (done[tbl[v].who] === 1'b1) dn = 1'b1;
        if (dn && got) break;
      end
      check("tbl_done", dn, 1);
      check("tbl_beats", beats, tbl[v].exp_beats);
      check("tbl_last_addr", last, tbl[v].exp_last);
      check("tbl_first_data", data, tbl[v].exp_data);
      wait_idle(60);
    end

    // Max-length burst with a competing request arriving during it.
    issue(0, 1'b0, 'h300, 255, '0);
    tick();
    issue(2, 1'b0, 'h050, 0, '0);
    beats = 0; tdone = -100; tg = -1;
    for (int t = 0; t < 400; t++) begin
      tick();
      if (mem_re === 1'b1) beats++;
      if (done[0] === 1'b1) tdone = cyc;
      if (grant[2] === 1'b1) begin
        tg = cyc;
        break;
      end
    end
    check("maxlen_beats", beats, 256);
    check("maxlen_grant2_after_done", tg - tdone, 1);
    wait_idle(60);

    // Reset during beat 2 of a 4-beat read.
    issue(0, 1'b0, 'h010, 3, '0);
    tgr = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (grant[0] === 1'b1) begin
        tgr = 1;
        break;
      end
    end
    check("rstb_granted", tgr, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("rstb_busy", busy, 0);
    check("rstb_mem_re", mem_re, 0);
    check("rstb_rd_valid", rd_valid, 0);
    check("rstb_done", done, 0);
    check("rstb_grant", grant, 0);
    issue(1, 1'b0, 'h030, 0, '0);
    issue(0, 1'b0, 'h010, 0, '0);
    tick();
    check("rstb_first_grant", grant, 3'b001);
    wait_idle(60);

    // Randomized traffic checked cycle by cycle against the model.
    rand_en = 1'b1;
    repeat (2500) tick();
    rand_en = 1'b0;
    wait_idle(300);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/extmem_arbiter.md
Name: extmem_arbiter

Overview:
- Round-robin arbiter and burst sequencer for the single-port external memory model.
- Lets NUM_REQ engines share the one read/write port: weight loader, input loader and output writer.
- Each requester issues a burst command: direction, start address and length. The arbiter owns the port for the whole burst.
- It generates one memory access per cycle and routes read data back to the owner.
- It sits in top, between the engines and the external memory interface.

Parameters:
- NUM_REQ, 3, number of requesters; index 0..NUM_REQ-1.
- ADDR_W, `ADDR_EXT_RAM, memory word address width.
- DATA_W, `DATA_EXT_RAM, memory word width.
- LEN_W, 8, burst length field width; beats per burst = len+1, giving 1..2**LEN_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_REQ  per-requester burst request
- req_we  in  NUM_REQ  1 = write burst, 0 = read burst
- req_addr  in  NUM_REQ*ADDR_W  start word address, flattened; slice i is [i*ADDR_W +: ADDR_W]
- req_len  in  NUM_REQ*LEN_W  beats minus one
- req_wdata  in  NUM_REQ*DATA_W  write data of the current beat
- grant  out  NUM_REQ  one-cycle pulse; command accepted
- wr_beat  out  NUM_REQ  write beat consumed this cycle; requester advances its data
- rd_valid  out  NUM_REQ  read data valid for owner
- rd_data  out  DATA_W  read data, broadcast to all requesters
- done  out  NUM_REQ  one-cycle pulse on the cycle the last beat is issued
- busy  out  1  burst in progress
- mem_re  out  1  memory read enable
- mem_rd_addr  out  ADDR_W  memory read address
- mem_rd_data  in  DATA_W  memory read data; valid one cycle after mem_re
- mem_we  out  1  memory write enable
- mem_wr_addr  out  ADDR_W  memory write address
- mem_wr_data  out  DATA_W  memory write data

Behaviour:
- Clocking: single clock clk; reset rst is synchronous and active-high.
- State machine: two states, IDLE and BURST.
- Reset values:
  - state = IDLE, rr_ptr = NUM_REQ-1, so requester 0 wins first.
  - grant, done, wr_beat, rd_valid, busy, mem_re and mem_we are all 0.
  - Address and count registers are 0; rd_valid tag is cleared.
- IDLE:
  - If any req is high, pick the first requester with req high, searching from rr_ptr+1 upward with wrap.
  - Register owner, we, addr and count=len. Pulse grant[owner]. Set rr_ptr=owner. Go to BURST.
  - If no req is high, stay in IDLE.
- BURST: one beat per cycle.
  - Read burst: mem_re=1, mem_rd_addr=addr.
  - Write burst: mem_we=1, mem_wr_addr=addr, mem_wr_data is combinationally the owner's req_wdata slice, wr_beat[owner]=1.
  - After each beat: addr += 1, wrapping modulo 2**ADDR_W; count -= 1.
  - When count==0 on the current beat: pulse done[owner] and return to IDLE.
- busy = (state==BURST).
- mem_re and mem_we are never both high.
- Latency:
  - req to first beat: 1 cycle.
  - Gap between consecutive bursts: 1 idle cycle, used for arbitration.
- Read return:
  - The issuing cycle's {re, owner} is registered.
  - rd_valid[owner_d] = re_d, asserted exactly one cycle after each mem_re.
  - rd_data = mem_rd_data, passed through combinationally.
  - The last read's return may overlap the next burst's IDLE or grant cycle. The tag makes this safe.
- Command stability:
  - req_we, req_addr and req_len must stay stable while req is high, until grant.
  - req may drop on or after grant. req high during the owner's own burst is ignored until IDLE.
- Write data: owner keeps req_wdata valid for the whole burst and advances it after each wr_beat cycle.
- Fairness: with all req held high, grants rotate 0,1,2,0,...
- Reset mid-burst: the burst is abandoned and no done is pulsed. A pending rd_valid is dropped on the following cycle (the tag is cleared).

Optional Feature:
- Macro: EXTMEM_ARB_STATS_EN.
- When defined:
  - Output port stat_busy_cycles (32 bits) counts cycles with busy=1.
  - Output port stat_bursts (NUM_REQ*16 bits) counts grants per requester.
  - Both counters saturate at all-ones and clear on rst.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package extmem_pkg holds:
  - localparam LEN_W.
  - typedef arb_state_e {IDLE, BURST}.
  - typedef for the burst command struct {we, addr, len}.
- One natural sub-module: rr_arbiter.
  - Combinational one-hot round-robin picker: inputs req and rr_ptr, output one-hot grant.
  - Reused later by the on-chip buffer arbiter.

Test Plan:
- Single read: req[0], addr=0x10, len=3, memory preloaded mem[0x10..0x13]=A,B,C,D.
  - grant[0] at T. mem_re at T+1..T+4 with addresses 0x10..0x13.
  - rd_valid[0] at T+2..T+5 with data A..D. done[0] at T+4.
- Single write: req[1], addr=0x200, len=0, wdata=0xCAFE.
  - One cycle with mem_we=1, wr_addr=0x200, wr_beat[1]=1, done[1]=1.
  - A read back returns 0xCAFE.
- Contention: all three req high continuously, each len=1.
  - Grants go 0,1,2,0,1,2. Each burst is 2 beats followed by a 1-cycle gap. mem_re and mem_we are never both high.
- Wrap: addr=2**ADDR_W-2, len=3.
  - Issued addresses are max-1, max, 0, 1.
- Max length: len=255.
  - Exactly 256 beats, then done.
  - A competing req[2] is granted only after done.
- Reset at beat 2 of a 4-beat read:
  - Next cycle: all outputs 0, no done, no stray rd_valid.
  - Then req[0] again is granted first.
